fabric_io_responder: RTL and testbench



---
 rtl/fabric_io_responder.sv | 146 ++++++++++++++
 tb/tb_fabric_io_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_io_responder.sv
// Fabric-side responder for a 4-phase req/ack nibble protocol on io[9:0].
// Serves 3-nibble read/write frames against an 8x8 register file with idle-timeout abort.
module fabric_io_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  RESET_SCRATCH  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] io_in,
    output logic [9:0] io_out,
    output logic [9:0] io_oeb
);

    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned NREGS  = 8;
    localparam int unsigned DATA_W = 8;

    typedef enum logic {WAIT_REQ, WAIT_REL} hs_e;
    typedef enum logic [1:0] {IDLE_CMD, D_HI, D_LO} fr_e;

    logic              req_m_q, req_m_d;
    logic              req_s_q, req_s_d;
    hs_e               hs_q, hs_d;
    fr_e               fr_q, fr_d;
    logic              ack_q, ack_d;
    logic [3:0]        resp_q, resp_d;
    logic              w_q, w_d;
    logic [2:0]        addr_q, addr_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [3:0]        wdata_hi_q, wdata_hi_d;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [3:0]        err_cnt_q, err_cnt_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic [3:0]        nib_c;
    logic [7:0]        rd_mux_c;
    logic              unused_pins;

    assign io_oeb      = 10'b00000_11111;
    assign io_out      = {ack_q, resp_q, 5'b0};
    assign nib_c       = io_in[3:0];
    assign unused_pins = ^io_in[9:5];

    // reg5 upper nibble always reads back the error counter
    assign rd_mux_c = (nib_c[2:0] == 3'd5) ? {err_cnt_q, regs_q[5][3:0]} : regs_q[nib_c[2:0]];

    always_comb begin
        req_m_d    = io_in[4];
        req_s_d    = req_m_q;
        hs_d       = hs_q;
        fr_d       = fr_q;
        ack_d      = ack_q;
        resp_d     = resp_q;
        w_d        = w_q;
        addr_d     = addr_q;
        rdata_d    = rdata_q;
        wdata_hi_d = wdata_hi_q;
        idle_cnt_d = idle_cnt_q;
        err_cnt_d  = err_cnt_q;
        regs_d     = regs_q;

        case (hs_q)
            WAIT_REQ: begin
                if (req_s_q) begin
                    hs_d       = WAIT_REL;
                    ack_d      = 1'b1;
                    idle_cnt_d = '0;
                    case (fr_q)
                        IDLE_CMD: begin
                            w_d    = nib_c[3];
                            addr_d = nib_c[2:0];
                            if (!nib_c[3]) rdata_d = rd_mux_c;
                            resp_d = {1'b1, nib_c[2:0]};
                            fr_d   = D_HI;
                        end
                        D_HI: begin
                            if (w_q) wdata_hi_d = nib_c;
                            resp_d = w_q ? 4'h0 : rdata_q[7:4];
                            fr_d   = D_LO;
                        end
                        default: begin
                            // reg7 counts frames and silently drops writes
                            regs_d[7] = regs_q[7] + 8'd1;
                            if (w_q && (addr_q != 3'd7)) regs_d[addr_q] = {wdata_hi_q, nib_c};
                            resp_d = w_q ? 4'h0 : rdata_q[3:0];
                            fr_d   = IDLE_CMD;
                        end
                    endcase
                end else if (fr_q != IDLE_CMD) begin
                    if (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        fr_d       = IDLE_CMD;
                        idle_cnt_d = '0;
                        if (err_cnt_q != 4'hF) err_cnt_d = err_cnt_q + 4'd1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CNT_W'(1);
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            default: begin
                if (!req_s_q) begin
                    hs_d   = WAIT_REQ;
                    ack_d  = 1'b0;
                    resp_d = 4'h0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_m_q    <= 1'b0;
            req_s_q    <= 1'b0;
            hs_q       <= WAIT_REQ;
            fr_q       <= IDLE_CMD;
            ack_q      <= 1'b0;
            resp_q     <= 4'h0;
            w_q        <= 1'b0;
            addr_q     <= 3'd0;
            rdata_q    <= 8'h00;
            wdata_hi_q <= 4'h0;
            idle_cnt_q <= '0;
            err_cnt_q  <= 4'h0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == 6) ? RESET_SCRATCH : 8'h00;
            end
        end else begin
            req_m_q    <= req_m_d;
            req_s_q    <= req_s_d;
            hs_q       <= hs_d;
            fr_q       <= fr_d;
            ack_q      <= ack_d;
            resp_q     <= resp_d;
            w_q        <= w_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            wdata_hi_q <= wdata_hi_d;
            idle_cnt_q <= idle_cnt_d;
            err_cnt_q  <= err_cnt_d;
            regs_q     <= regs_d;
        end
    end

endmodule

// File: tb/tb_fabric_io_responder.sv
// Bench for fabric_io_responder: host-side nibble protocol driver with a frame-level reference model.
module tb_fabric_io_responder;

    localparam int TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] io_in;
    logic [9:0] io_out;
    logic [9:0] io_oeb;

    int n_checks = 0;
    int n_fail   = 0;

    fabric_io_responder #(.TIMEOUT_CYCLES(TIMEOUT), .RESET_SCRATCH(8'hA5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_in  (io_in),
        .io_out (io_out),
        .io_oeb (io_oeb)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: register file plus frame position ----------------
    logic [7:0] m_regs [8];
    int         m_err;
    int         m_pos;
    bit         m_w;
    int         m_addr;
    logic [7:0] m_snap;
    logic [3:0] m_hi;

    function automatic void m_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_regs[6] = 8'hA5;
        m_err = 0; m_pos = 0; m_w = 0; m_addr = 0; m_snap = 8'h00; m_hi = 4'h0;
    endfunction

    function automatic logic [3:0] m_xfer(input logic [3:0] nib);
        logic [3:0] r;
        if (m_pos == 0) begin
            m_w    = nib[3];
            m_addr = int'(nib[2:0]);
            m_snap = (m_addr == 5) ? {4'(m_err), m_regs[5][3:0]} : m_regs[m_addr];
            r      = {1'b1, nib[2:0]};
            m_pos  = 1;
        end else if (m_pos == 1) begin
            m_hi  = nib;
            r     = m_w ? 4'h0 : m_snap[7:4];
            m_pos = 2;
        end else begin
            if (m_w && m_addr != 7) m_regs[m_addr] = {m_hi, nib};
            m_regs[7] = m_regs[7] + 8'd1;
            r     = m_w ? 4'h0 : m_snap[3:0];
            m_pos = 0;
        end
        return r;
    endfunction

    function automatic void m_timeout();
        if (m_pos != 0) begin
            m_pos = 0;
            if (m_err < 15) m_err = m_err + 1;
        end
    endfunction

    // ---------------- host helpers ----------------
    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic xfer(input logic [3:0] nib, output logic [3:0] resp);
        int n;
        @(negedge clk);
        io_in[9:5] = 5'($urandom);
        io_in[3:0] = nib;
        io_in[4]   = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!io_out[9] && n < 20);
        if (!io_out[9]) begin
            n_checks++; n_fail++;
            $display("FAIL ack_rise_timeout: got ack=0 expected ack=1 after %0d edges", n);
        end
        resp = io_out[8:5];
        check("low_pins_zero", {5'b0, io_out[4:0]}, 10'h000);
        @(negedge clk);
        io_in[4] = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (io_out[9] && n < 20);
        if (io_out[9]) begin
            n_checks++; n_fail++;
            $display("FAIL ack_fall_timeout: got ack=1 expected ack=0 after %0d edges", n);
        end
    endtask

    task automatic do_xfer(input string name, input logic [3:0] nib);
        logic [3:0] r;
        logic [3:0] e;
        xfer(nib, r);
        e = m_xfer(nib);
        check(name, {6'b0, r}, {6'b0, e});
    endtask

    task automatic do_frame(input string name, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        do_xfer({name, "_n0"}, a);
        do_xfer({name, "_n1"}, b);
        do_xfer({name, "_n2"}, c);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        io_in = 10'($urandom);
        rst_n = 1'b0;
        #3;
        check("rst_oeb", io_oeb, 10'h01F);
        check("rst_out", io_out, 10'h000);
        repeat (3) @(negedge clk);
        io_in[4] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] nib;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [21];

    initial begin
        logic [3:0] r;
        rst_n = 1'b0;
        io_in = 10'h000;
        m_reset();

        vecs = '{
            '{4'h6, 4'hE}, '{4'h0, 4'hA}, '{4'h0, 4'h5},
            '{4'hA, 4'hA}, '{4'h3, 4'h0}, '{4'hC, 4'h0},
            '{4'h2, 4'hA}, '{4'h0, 4'h3}, '{4'h0, 4'hC},
            '{4'hF, 4'hF}, '{4'hF, 4'h0}, '{4'hF, 4'h0},
            '{4'h7, 4'hF}, '{4'h0, 4'h0}, '{4'h0, 4'h4},
            '{4'hD, 4'hD}, '{4'hF, 4'h0}, '{4'h7, 4'h0},
            '{4'h5, 4'hD}, '{4'h0, 4'h0}, '{4'h0, 4'h7}
        };

        apply_reset();

        // table: reg6 reset read, reg2 write/readback, reg7 write drop, reg5 split
        for (int i = 0; i < 21; i++) begin
            logic [3:0] e;
            xfer(vecs[i].nib, r);
            e = m_xfer(vecs[i].nib);
            check($sformatf("vec%0d", i), {6'b0, r}, {6'b0, vecs[i].exp});
        end

        // handshake latency and long req hold
        repeat (4) @(negedge clk);
        io_in[3:0] = 4'h6;
        io_in[4]   = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            check($sformatf("ack_rise_edge%0d", e), {9'b0, io_out[9]}, (e == 3) ? 10'h001 : 10'h000);
        end
        check("timing_resp", {6'b0, io_out[8:5]}, {6'b0, m_xfer(4'h6)});
        repeat (50) @(posedge clk);
        #1;
        check("ack_held_50", {9'b0, io_out[9]}, 10'h001);
        @(negedge clk);
        io_in[4] = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            check($sformatf("ack_fall_edge%0d", e), {9'b0, io_out[9]}, (e == 3) ? 10'h000 : 10'h001);
        end
        check("resp_cleared", {6'b0, io_out[8:5]}, 10'h000);
        do_xfer("timing_n1", 4'h0);
        do_xfer("timing_n2", 4'h0);

        // frame counter wrap with randomized frames
        apply_reset();
        do_frame("rd6", 4'h6, 4'h0, 4'h0);
        for (int f = 0; f < 257; f++) begin
            for (int k = 0; k < 3; k++) begin
                do_xfer($sformatf("rnd%0d_%0d", f, k), 4'($urandom));
                repeat ($urandom_range(0, 6)) @(negedge clk);
            end
        end
        xfer(4'h7, r); check("rd7_cmd", {6'b0, r}, {6'b0, m_xfer(4'h7)});
        xfer(4'h0, r); check("rd7_hi",  {6'b0, r}, {6'b0, m_xfer(4'h0)});
        xfer(4'h0, r); check("rd7_lo",  {6'b0, r}, {6'b0, m_xfer(4'h0)});
        check("rd7_is_02", {6'b0, r}, 10'h002);
        do_frame("wr7", 4'hF, 4'hF, 4'hF);
        do_frame("rd7b", 4'h7, 4'h0, 4'h0);

        // timeout abort mid write
        do_frame("wr1", 4'h9, 4'h1, 4'h2);
        do_xfer("to_cmd", 4'h9);
        do_xfer("to_hi", 4'h7);
        repeat (TIMEOUT + 20) @(negedge clk);
        m_timeout();
        do_frame("to_rd1", 4'h1, 4'h0, 4'h0);
        check("reg1_kept", {2'b0, m_regs[1]}, 10'h012);
        do_frame("to_rd5", 4'h5, 4'h0, 4'h0);

        // idle just under the limit must not abort
        do_xfer("nm_cmd", 4'hB);
        repeat (TIMEOUT - 40) @(negedge clk);
        do_xfer("nm_hi", 4'h6);
        repeat (TIMEOUT - 40) @(negedge clk);
        do_xfer("nm_lo", 4'h9);
        do_frame("nm_rd3", 4'h3, 4'h0, 4'h0);
        do_frame("nm_rd5", 4'h5, 4'h0, 4'h0);

        // asynchronous reset while ack is held, req left high through release
        do_frame("pre_wr2", 4'hA, 4'h5, 4'h5);
        @(negedge clk);
        io_in[3:0] = 4'h2;
        io_in[4]   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("pre_async_ack", {9'b0, io_out[9]}, 10'h001);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_ack_drop", io_out, 10'h000);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int n = 0;
            do begin @(posedge clk); #1; n++; end while (!io_out[9] && n < 20);
            check("held_req_ack", {9'b0, io_out[9]}, 10'h001);
        end
        check("held_req_resp", {6'b0, io_out[8:5]}, {6'b0, m_xfer(4'h2)});
        @(negedge clk);
        io_in[4] = 1'b0;
        repeat (5) @(negedge clk);
        do_xfer("post_n1", 4'h0);
        do_xfer("post_n2", 4'h0);
        do_frame("post_rd6", 4'h6, 4'h0, 4'h0);
        do_frame("post_rd5", 4'h5, 4'h0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
